sha256_blk_ctrl: RTL and testbench

Sequencer for the SHA-256 compression datapath. It accepts one 512-bit message block as WORDS 64-bit beats over a valid/ready handshake and issues one-hot load strobes to the bank of 64-bit start-gated message registers. It then runs the round counter and pulses the working-variable init and hash-update enables. It sits between the host/padding interface and the message-register bank / round core.

---
 rtl/sha256_blk_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sha256_blk_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_blk_ctrl.sv
// sha256_blk_ctrl: block sequencer for the SHA-256 compression datapath.
// Accepts one 512-bit block as WORDS beats over valid/ready, issues one-hot
// load strobes to the message-register bank, then drives the working-variable
// init, NUM_ROUNDS round cycles, the hash update and a done pulse.
// Optional feature macro: SHA256_BLK_CTRL_PERF_EN adds the saturating
// completed-block counter output blk_cnt.
module sha256_blk_ctrl #(
  parameter int WORDS      = 8,
  parameter int NUM_ROUNDS = 64,
  parameter int RIDX_W     = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic              msg_first,
  input  logic              abort,
  output logic [WORDS-1:0]  word_ld,
  output logic              iv_ld,
  output logic              wv_init,
  output logic              round_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic              hash_upd,
  output logic              busy,
  output logic              done
`ifdef SHA256_BLK_CTRL_PERF_EN
  ,
  output logic [31:0]       blk_cnt
`endif
);

  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
  localparam logic [RIDX_W-1:0] LAST_RND  = RIDX_W'(NUM_ROUNDS - 1);
  localparam logic [WORDS-1:0]  BEAT0_HOT = WORDS'(1);

  // The round index must be able to represent every round number.
  if ((1 << RIDX_W) < NUM_ROUNDS) begin : g_ridx_too_narrow
    $error("RIDX_W too narrow for NUM_ROUNDS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;

  // Registered phase flags; each mirrors one state so outputs come off flops.
  logic busy_q;
  logic init_q;
  logic round_q;
  logic upd_q;
  logic done_q;

  logic accept_st;
  logic hs;
  logic kill;

  // Beats are only taken while collecting a block; reset and abort close the port.
  assign accept_st = (state == S_IDLE) || (state == S_LOAD);
  assign msg_ready = RST && accept_st && !abort;
  assign hs        = msg_valid && msg_ready;

  // An abort outside IDLE suppresses every strobe of the current cycle.
  assign kill      = abort && busy_q;

  assign word_ld   = hs ? (BEAT0_HOT << beat_cnt) : '0;
  assign iv_ld     = hs && (state == S_IDLE) && msg_first;
  assign wv_init   = init_q  && !kill;
  assign round_en  = round_q && !kill;
  assign hash_upd  = upd_q   && !kill;
  assign done      = done_q  && !kill;
  assign busy      = busy_q;

  // Block sequencer: state, beat counter, round counter and phase flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      round_idx <= '0;
      busy_q    <= 1'b0;
      init_q    <= 1'b0;
      round_q   <= 1'b0;
      upd_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (kill) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      round_idx <= '0;
      busy_q    <= 1'b0;
      init_q    <= 1'b0;
      round_q   <= 1'b0;
      upd_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (hs) begin
            busy_q <= 1'b1;
            if (beat_cnt == LAST_BEAT) begin
              state    <= S_INIT;
              beat_cnt <= '0;
              init_q   <= 1'b1;
            end else begin
              state    <= S_LOAD;
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        S_INIT: begin
          state     <= S_ROUND;
          round_idx <= '0;
          init_q    <= 1'b0;
          round_q   <= 1'b1;
        end
        S_ROUND: begin
          if (round_idx == LAST_RND) begin
            state   <= S_UPDATE;
            round_q <= 1'b0;
            upd_q   <= 1'b1;
          end else begin
            round_idx <= round_idx + RIDX_W'(1);
          end
        end
        S_UPDATE: begin
          state  <= S_DONE;
          upd_q  <= 1'b0;
          done_q <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          round_idx <= '0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          beat_cnt  <= '0;
          round_idx <= '0;
          busy_q    <= 1'b0;
          init_q    <= 1'b0;
          round_q   <= 1'b0;
          upd_q     <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHA256_BLK_CTRL_PERF_EN
  // Completed-block counter: restarts with a new message, saturates at all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blk_cnt <= '0;
    end else if (iv_ld) begin
      blk_cnt <= '0;
    end else if (hash_upd && (blk_cnt != 32'hFFFF_FFFF)) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_blk_ctrl.sv
// Testbench for sha256_blk_ctrl: a timeline model predicts every output each
// cycle from beat counts and the distance since the last accepted beat.
module tb_sha256_blk_ctrl;

  localparam int W  = 8;
  localparam int NR = 64;
  localparam int RW = 6;

  logic          CLK;
  logic          RST;
  logic          msg_valid;
  logic          msg_ready;
  logic          msg_first;
  logic          abort;
  logic [W-1:0]  word_ld;
  logic          iv_ld;
  logic          wv_init;
  logic          round_en;
  logic [RW-1:0] round_idx;
  logic          hash_upd;
  logic          busy;
  logic          done;
`ifdef SHA256_BLK_CTRL_PERF_EN
  logic [31:0]   blk_cnt;
`endif

  sha256_blk_ctrl #(.WORDS(W), .NUM_ROUNDS(NR), .RIDX_W(RW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg_first (msg_first),
    .abort     (abort),
    .word_ld   (word_ld),
    .iv_ld     (iv_ld),
    .wv_init   (wv_init),
    .round_en  (round_en),
    .round_idx (round_idx),
    .hash_upd  (hash_upd),
    .busy      (busy),
    .done      (done)
`ifdef SHA256_BLK_CTRL_PERF_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Observed event log
  int hs_cnt = 0, iv_cnt = 0, rnd_cnt = 0, done_cnt = 0, upd_cnt = 0;
  int last_hs_cyc = 0, wv_cyc = 0, upd_cyc = 0, done_cyc = 0;
  int rnd_base = 0;

  // Model state: beats taken of the current block, cycles since the last beat
  // of a block (0 = no block compressing), completed-block count.
  int          m_beat = 0;
  int          m_tail = 0;
  logic [31:0] m_blk  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Per-cycle compare against the timeline model
  always @(negedge CLK) begin : monitor
    logic         m_busy, e_rdy, e_hs, e_iv, kill;
    logic         e_wv, e_ren, e_upd, e_done;
    logic [W-1:0] e_word;
    logic [31:0]  e_blk;
    m_busy = (m_beat != 0) || (m_tail != 0);
    e_rdy  = RST && (m_tail == 0) && !abort;
    e_hs   = e_rdy && msg_valid;
    e_word = '0;
    if (e_hs) e_word[m_beat] = 1'b1;
    e_iv   = e_hs && (m_beat == 0) && msg_first;
    kill   = abort && m_busy;
    e_wv   = RST && !kill && (m_tail == 1);
    e_ren  = RST && !kill && (m_tail >= 2) && (m_tail <= NR + 1);
    e_upd  = RST && !kill && (m_tail == NR + 2);
    e_done = RST && !kill && (m_tail == NR + 3);
    e_blk  = RST ? m_blk : 32'd0;

    chk("msg_ready", 64'(msg_ready), 64'(e_rdy));
    chk("word_ld",   64'(word_ld),   64'(e_word));
    chk("iv_ld",     64'(iv_ld),     64'(e_iv));
    chk("wv_init",   64'(wv_init),   64'(e_wv));
    chk("round_en",  64'(round_en),  64'(e_ren));
    chk("hash_upd",  64'(hash_upd),  64'(e_upd));
    chk("done",      64'(done),      64'(e_done));
    chk("busy",      64'(busy),      64'(RST && m_busy));
    if (!RST)
      chk("round_idx_rst", 64'(round_idx), 64'd0);
    else if (m_tail <= NR + 1)
      chk("round_idx", 64'(round_idx), (m_tail >= 2) ? 64'(m_tail - 2) : 64'd0);
`ifdef SHA256_BLK_CTRL_PERF_EN
    chk("blk_cnt", 64'(blk_cnt), 64'(e_blk));
`endif

    if (msg_valid && msg_ready) begin hs_cnt++; last_hs_cyc = cyc; end
    if (iv_ld)    iv_cnt++;
    if (wv_init)  wv_cyc = cyc;
    if (round_en) rnd_cnt++;
    if (hash_upd) begin upd_cnt++; upd_cyc = cyc; end
    if (done)     begin done_cnt++; done_cyc = cyc; end

    if (!RST) begin
      m_beat = 0;
      m_tail = 0;
      m_blk  = '0;
    end else begin
      if (e_iv) m_blk = '0;
      else if (e_upd && (m_blk != 32'hFFFF_FFFF)) m_blk = m_blk + 32'd1;
      if (kill) begin
        m_beat = 0;
        m_tail = 0;
      end else if (e_hs) begin
        if (m_beat == W - 1) begin m_beat = 0; m_tail = 1; end
        else m_beat = m_beat + 1;
      end else if (m_tail != 0) begin
        m_tail = (m_tail == NR + 3) ? 0 : m_tail + 1;
      end
    end
  end

  // Send nb beats; a gap of bub_len idle cycles precedes beat bub_at.
  task automatic send_block(input logic first, input int nb, input int bub_at, input int bub_len);
    int  h0;
    logic ok;
    rnd_base = rnd_cnt;
    for (int b = 0; b < nb; b++) begin
      if (b == bub_at) begin
        msg_valid = 1'b0;
        repeat (bub_len) @(posedge CLK);
        #1;
      end
      msg_valid = 1'b1;
      msg_first = (b == 0) ? first : 1'($urandom);
      h0 = hs_cnt;
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
        @(posedge CLK);
        if (hs_cnt != h0) begin ok = 1'b1; break; end
      end
      chk("beat_accept", 64'(ok), 64'd1);
      #1;
    end
    msg_valid = 1'b0;
    msg_first = 1'b0;
  endtask

  task automatic wait_done();
    int   d0;
    logic ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge CLK);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    chk("done_seen", 64'(ok), 64'd1);
    #1;
  endtask

  // Literal latencies for the default 8-beat, 64-round configuration
  task automatic check_tail(input string tag);
    chk({tag, "_wv_lat"},   64'(wv_cyc - last_hs_cyc),   64'd1);
    chk({tag, "_upd_lat"},  64'(upd_cyc - last_hs_cyc),  64'd66);
    chk({tag, "_done_lat"}, 64'(done_cyc - last_hs_cyc), 64'd67);
    chk({tag, "_rounds"},   64'(rnd_cnt - rnd_base),     64'd64);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   i0, d0, u0, h0;
    logic found;
    RST = 1'b1; msg_valid = 1'b0; msg_first = 1'b0; abort = 1'b0;
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_idx",   64'(round_idx), 64'd0);
    chk("rst_ready", 64'(msg_ready), 64'd1);
    @(posedge CLK); #1;

    // First block of a message, back-to-back beats
    send_block(1'b1, W, -1, 0);
    wait_done();
    check_tail("blk1");
    chk("blk1_iv", 64'(iv_cnt), 64'd1);

    // Bubble of 3 cycles between beats 3 and 4
    send_block(1'b0, W, 4, 3);
    wait_done();
    check_tail("bubble");

    // Back-to-back block, continuation of message
    send_block(1'b0, W, -1, 0);
    wait_done();
    check_tail("b2b");
    chk("b2b_no_iv", 64'(iv_cnt), 64'd1);

    // Abort in IDLE blocks the beat
    h0 = hs_cnt;
    abort = 1'b1; msg_valid = 1'b1; msg_first = 1'b1;
    @(posedge CLK); #1;
    chk("idle_abort_hs", 64'(hs_cnt), 64'(h0));
    abort = 1'b0; msg_valid = 1'b0; msg_first = 1'b0;

    // Abort at round 20
    send_block(1'b0, W, -1, 0);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (round_en && (round_idx == RW'(19))) begin found = 1'b1; break; end
    end
    chk("abort_found_r19", 64'(found), 64'd1);
    @(posedge CLK); #1;
    d0 = done_cnt; u0 = upd_cnt;
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy),      64'd0);
    chk("abort_idx",  64'(round_idx), 64'd0);
    repeat (80) @(posedge CLK); #1;
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    chk("abort_no_upd",  64'(upd_cnt),  64'(u0));
    send_block(1'b0, W, -1, 0);
    wait_done();
    check_tail("post_abort");

    // Abort during LOAD with a beat offered
    send_block(1'b1, 3, -1, 0);
    abort = 1'b1; msg_valid = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0; msg_valid = 1'b0;
    chk("load_abort_busy", 64'(busy), 64'd0);
    i0 = iv_cnt;
    send_block(1'b1, W, -1, 0);
    wait_done();
    check_tail("post_load_abort");
    chk("post_load_abort_iv", 64'(iv_cnt - i0), 64'd1);

    // Reset while beat 5 is offered
    send_block(1'b0, 5, -1, 0);
    msg_valid = 1'b1;
    RST = 1'b0;
    #1;
    chk("async_busy",    64'(busy),      64'd0);
    chk("async_ready",   64'(msg_ready), 64'd0);
    chk("async_word_ld", 64'(word_ld),   64'd0);
`ifdef SHA256_BLK_CTRL_PERF_EN
    chk("async_blk_cnt", 64'(blk_cnt),   64'd0);
`endif
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    msg_valid = 1'b0;
    send_block(1'b1, W, -1, 0);
    wait_done();
    check_tail("post_rst");

    // Two more continuation blocks, then a fresh message
    send_block(1'b0, W, -1, 0);
    wait_done();
    send_block(1'b0, W, -1, 0);
    wait_done();
`ifdef SHA256_BLK_CTRL_PERF_EN
    chk("perf_three", 64'(blk_cnt), 64'd3);
`endif
    send_block(1'b1, W, -1, 0);
    wait_done();
    check_tail("fresh_msg");
`ifdef SHA256_BLK_CTRL_PERF_EN
    chk("perf_restart", 64'(blk_cnt), 64'd1);
`endif

    repeat (4) @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
